// File: rtl/shift_pkg.sv
// Shared state encoding and saturation-limit helpers for the sequential shifters.
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Limits are computed in 64 bits; callers truncate to their own width.
  localparam int unsigned SAT_CALC_W = 64;

  // Largest positive two's-complement value for a w-bit operand.
  function automatic logic [SAT_CALC_W-1:0] sat_max(input int unsigned w);
    sat_max = (SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1);
  endfunction

  // Most negative two's-complement value (bit pattern) for a w-bit operand.
  function automatic logic [SAT_CALC_W-1:0] sat_min(input int unsigned w);
    sat_min = SAT_CALC_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/seq_arith_shift_left.sv
// Sequential arithmetic left shifter: one bit per clock, sticky signed
// overflow detection, optional saturation of the final result.
module seq_arith_shift_left
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SHW      = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             sticky;
  logic             sgn;

  logic [WIDTH-1:0] acc_shl;
  logic             sticky_nxt;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             enter_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == SHW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One shift step and the result that would be published on entering DONE.
  always_comb begin
    acc_shl    = {acc[WIDTH-2:0], 1'b0};
    sticky_nxt = sticky | (acc[WIDTH-1] ^ acc[WIDTH-2]);
    res        = acc_shl;
    res_ovf    = sticky_nxt;
    enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    if (state_q == ST_IDLE) begin
      // Zero-length shift: operand passes through unchanged.
      res     = a;
      res_ovf = 1'b0;
    end
    if (SATURATE && res_ovf) begin
      res = sgn ? SAT_MIN : SAT_MAX;
    end
  end

  // Working registers: load on accept, shift in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      sgn    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc    <= a;
            cnt    <= amount;
            sticky <= 1'b0;
            sgn    <= a[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          acc    <= acc_shl;
          sticky <= sticky_nxt;
          cnt    <= cnt - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; y/ovf change only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      y    <= '0;
      ovf  <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= enter_done;
      if (enter_done) begin
        y   <= res;
        ovf <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_shift_left.sv
// Randomized and directed check of seq_arith_shift_left against an
// arithmetic reference model (exact product vs. signed range).
module tb_seq_arith_shift_left;

  localparam int unsigned W   = 8;
  localparam int unsigned SHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [SHW-1:0] amount;

  logic           busy0, done0, ovf0;
  logic [W-1:0]   y0;
  logic           busy1, done1, ovf1;
  logic [W-1:0]   y1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_arith_shift_left #(.WIDTH(W), .SHW(SHW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .a(a), .amount(amount),
    .busy(busy0), .done(done0), .y(y0), .ovf(ovf0)
  );

  seq_arith_shift_left #(.WIDTH(W), .SHW(SHW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .a(a), .amount(amount),
    .busy(busy1), .done(done1), .y(y1), .ovf(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product a*2^amt; overflow iff it leaves the signed W-bit range.
  task automatic ref_model(input logic [W-1:0] op, input int amt, input bit sat,
                           output logic [W-1:0] ry, output bit rovf);
    longint sa;
    longint p;
    sa   = longint'(signed'(op));
    p    = sa * (longint'(1) << amt);
    rovf = (p > 127) || (p < -128);
    if (sat && rovf) ry = op[W-1] ? 8'h80 : 8'h7F;
    else             ry = p[W-1:0];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle and check latency, busy and results.
  // When poke is set, a start is driven during the DONE cycle and must be ignored.
  task automatic run_op(input logic [W-1:0] op, input int amt, input bit poke);
    logic [W-1:0] ey0, ey1;
    bit           eo0, eo1;
    int           done_cyc;
    ref_model(op, amt, 1'b0, ey0, eo0);
    ref_model(op, amt, 1'b1, ey1, eo1);
    start    = 1'b1;
    a        = op;
    amount   = SHW'(amt);
    done_cyc = -1;
    next_cycle();
    start = 1'b0;
    a     = W'($urandom);
    for (int c = 1; c <= 20; c++) begin
      check_eq("busy_in_flight", {31'd0, busy0}, 32'd1);
      if (done0) begin
        done_cyc = c;
        check_eq("y_wrap", {24'd0, y0}, {24'd0, ey0});
        check_eq("ovf_wrap", {31'd0, ovf0}, {31'd0, eo0});
        check_eq("y_sat", {24'd0, y1}, {24'd0, ey1});
        check_eq("ovf_sat", {31'd0, ovf1}, {31'd0, eo1});
        check_eq("done_sat_align", {31'd0, done1}, 32'd1);
        break;
      end
      next_cycle();
    end
    check_eq("latency", 32'(done_cyc), 32'(amt + 1));
    if (poke) begin
      start  = 1'b1;
      a      = 8'h11;
      amount = '0;
    end
    next_cycle();
    start = 1'b0;
    check_eq("done_single_pulse", {31'd0, done0}, 32'd0);
    check_eq("busy_back_idle", {31'd0, busy0}, 32'd0);
    if (poke) begin
      next_cycle();
      check_eq("poke_ignored_done", {31'd0, done0}, 32'd0);
      check_eq("poke_ignored_busy", {31'd0, busy0}, 32'd0);
      check_eq("y_held", {24'd0, y0}, {24'd0, ey0});
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    amount = '0;
    repeat (3) next_cycle();
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_y", {24'd0, y0}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf1}, 32'd0);
    rst = 1'b0;
    next_cycle();

    // Directed cases from the plan.
    run_op(8'h03, 2, 1'b0);
    run_op(8'hFD, 5, 1'b0);
    run_op(8'h40, 1, 1'b0);
    run_op(8'h80, 1, 1'b0);
    run_op(8'h5A, 0, 1'b1);
    run_op(8'h01, 7, 1'b0);
    run_op(8'hFF, 7, 1'b0);

    // Reset in the middle of a long shift.
    start  = 1'b1;
    a      = 8'h25;
    amount = 3'd7;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, busy0}, 32'd0);
    check_eq("midrst_done", {31'd0, done0}, 32'd0);
    check_eq("midrst_y", {24'd0, y0}, 32'd0);
    check_eq("midrst_ovf", {31'd0, ovf0}, 32'd0);
    check_eq("midrst_sat_y", {24'd0, y1}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      check_eq("midrst_no_done", {31'd0, done0 | done1}, 32'd0);
      if (k == 0) break;
    end
    run_op(8'h25, 2, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      run_op(W'($urandom), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_arith_shift_left.md
# seq_arith_shift_left

Sequential arithmetic left shifter that complements the team's combinational arithmetic right shifter. It accepts a signed operand and a shift amount over a start/done handshake. It shifts one bit position per clock and flags signed overflow. Saturation of the result on overflow is optional. It sits in the datapath wherever a scale-up by 2^n is needed and per-bit overflow tracking must not create a long combinational path.

## Interface
- `WIDTH`, default 8: operand/result width in bits; must be ≥ 2.
- `SHW`, default 3: shift-amount width in bits; maximum shift is 2^SHW − 1.
- `SATURATE`, default 0: when 1, an overflowed result is clamped to the signed max or min.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  signed operand; sampled with `start`
- `amount`  in  SHW  shift count; sampled with `start`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse; `y` and `ovf` are valid in this cycle
- `y`  out  WIDTH  signed result; held until the next `done`
- `ovf`  out  1  signed overflow of the last operation; held with `y`

## Operation
- States:
  - IDLE → SHIFT when `start` is sampled and `amount` ≠ 0.
  - IDLE → DONE when `start` is sampled and `amount` = 0.
  - SHIFT → DONE after the final shift.
  - DONE → IDLE unconditionally.
- On accept: latch `a` into the working register `acc`; `cnt` ← `amount`; clear the sticky overflow flag; latch `sgn` ← `a[WIDTH-1]`.
- In SHIFT, each cycle:
  - `acc` ← `acc` << 1, with zero fill.
  - If `acc[WIDTH-1]` ≠ `acc[WIDTH-2]` before the shift, set the sticky overflow flag.
  - `cnt` decrements; when `cnt` = 1, the next state is DONE.
- In DONE: `done` = 1 and `ovf` = sticky flag.
  - With `SATURATE`=0, or no overflow: `y` = `acc`. The result is modulo 2^WIDTH.
  - With `SATURATE`=1 and overflow: `y` = 2^(WIDTH-1) − 1 if `sgn` = 0, else −2^(WIDTH-1).
- `y` and `ovf` are registered. They update only on the edge that enters DONE.
- `start` while `busy` = 1 is ignored, including during the DONE cycle. There is no queueing.
- Reset, at any time including mid-shift:
  - State → IDLE.
  - `busy`=0, `done`=0, `y`=0, `ovf`=0.
  - `acc`, `cnt` and the sticky flag are cleared.
  - The in-flight operation is discarded; no `done` is produced for it.

## Timing
- `start` is sampled at the end of cycle 0.
- Cycles 1..`amount` are in SHIFT, with `busy`=1.
- Cycle `amount`+1 is DONE: `done`=1, `busy`=1, and `y`/`ovf` are valid.
- Cycle `amount`+2 is IDLE, where a new `start` is accepted.
- Latency from `start` to `done` is `amount`+1 cycles. Throughput is one operation per `amount`+2 cycles.
- `amount` = 0: `done` in cycle 1 with `y` = `a` and `ovf` = 0.
- `amount` ≥ `WIDTH`: the shift proceeds normally and `acc` becomes 0. `ovf` is set if any 1 bit, or for negative operands any sign transition, passed through bit WIDTH-2.
- `done` is never high in two consecutive cycles.

## Structure
- Shared package `shift_pkg` holds:
  - The state localparams `ST_IDLE`, `ST_SHIFT`, `ST_DONE`, in a 2-bit encoding.
  - The saturation-limit helper constants, derived from `WIDTH`.
- The package is reused by the right shifter's future sequential variant.
- Single module. No sub-module is warranted: the counter and datapath are a handful of registers.

## Test plan
- `a`=3, `amount`=2, SAT=0 → `done` in cycle 3, `y`=12, `ovf`=0, `busy` high in cycles 1–3.
- `a`=−3 (0xFD), `amount`=5 → `y`=0xA0 (−96), `ovf`=0, `done` in cycle 6.
- `a`=0x40, `amount`=1:
  - SAT=0 → `y`=0x80, `ovf`=1.
  - SAT=1 → `y`=0x7F, `ovf`=1.
- `a`=0x80 (−128), `amount`=1:
  - SAT=0 → `y`=0x00, `ovf`=1.
  - SAT=1 → `y`=0x80.
- `a`=0x5A, `amount`=0 → `done` in cycle 1, `y`=0x5A, `ovf`=0. Then pulse `start` in the DONE cycle → ignored, with no second `done`.
- `amount`=7 with `rst` asserted in cycle 3 → no `done`; all outputs 0 on the following cycle; a new `start` is accepted the cycle after `rst` deasserts.
